cpu_ctrl_seq: RTL and testbench

Fetch/decode/execute control sequencer for the simple accumulator CPU. It sits directly upstream of the datapath registers (PC, AR, IR, DR, AC) and drives their load/inc strobes, the memory read/write strobes and the ALU select. It guarantees that no register ever receives load and inc in the same cycle.

---
 rtl/cpu_ctrl_pkg.sv | 31 +++
 rtl/cpu_ctrl_out_decode.sv | 73 +++++++
 rtl/cpu_ctrl_seq.sv | 81 ++++++++
 tb/tb_cpu_ctrl_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types for the accumulator CPU control sequencer.
package cpu_ctrl_pkg;
  localparam int OPC_W = 3;
  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 3'd0,
    OP_LDAC = 3'd1,
    OP_STAC = 3'd2,
    OP_ADD  = 3'd3,
    OP_INAC = 3'd4,
    OP_JMP  = 3'd5,
    OP_JMPZ = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;
  typedef enum logic [3:0] {
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_EXEC,
    S_MEM_WR,
    S_HALT
`ifdef CPU_CTRL_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;
  typedef enum logic {
    ALU_PASS = 1'b0,
    ALU_ADD  = 1'b1
  } alu_op_t;
endpackage

// File: rtl/cpu_ctrl_out_decode.sv
// cpu_ctrl_out_decode: combinational map from sequencer state and inputs to datapath strobes.
module cpu_ctrl_out_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t  state,
  input  opcode_t opc,
  input  logic    z_flag,
  input  logic    mem_ready,
  input  logic    rst,
  output logic    pc_load,
  output logic    pc_inc,
  output logic    ar_load,
  output logic    ar_src,
  output logic    ir_load,
  output logic    dr_load,
  output logic    ac_load,
  output logic    ac_inc,
  output logic    alu_op,
  output logic    mem_rd,
  output logic    mem_wr,
  output logic    instr_done,
  output logic    halted
);
  always_comb begin
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    ar_load    = 1'b0;
    ar_src     = 1'b0;
    ir_load    = 1'b0;
    dr_load    = 1'b0;
    ac_load    = 1'b0;
    ac_inc     = 1'b0;
    alu_op     = ALU_PASS;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH1: ar_load = 1'b1;
        S_FETCH2: begin
          mem_rd  = 1'b1;
          ir_load = mem_ready;
          pc_inc  = mem_ready;
        end
        S_DECODE: begin
          instr_done = opc inside {OP_NOP, OP_INAC, OP_JMP, OP_JMPZ};
          ac_inc     = opc == OP_INAC;
          pc_load    = opc == OP_JMP || (opc == OP_JMPZ && z_flag);
        end
        S_MEM_ADDR: begin
          ar_load = 1'b1;
          ar_src  = 1'b1;
        end
        S_MEM_RD: begin
          mem_rd  = 1'b1;
          dr_load = mem_ready;
        end
        S_EXEC: begin
          ac_load    = 1'b1;
          alu_op     = opc == OP_ADD ? ALU_ADD : ALU_PASS;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_wr     = 1'b1;
          instr_done = mem_ready;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: fetch/decode/execute sequencer for the accumulator CPU.
// Optional single-step hold after each instruction with CPU_CTRL_SINGLE_STEP_EN.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IR_W-1:0] ir,
  input  logic            z_flag,
  input  logic            mem_ready,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            pc_load,
  output logic            pc_inc,
  output logic            ar_load,
  output logic            ar_src,
  output logic            ir_load,
  output logic            dr_load,
  output logic            ac_load,
  output logic            ac_inc,
  output logic            alu_op,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            instr_done,
  output logic            halted
);
`ifdef CPU_CTRL_SINGLE_STEP_EN
  localparam state_t DONE_ST = S_STEP_WAIT;
`else
  localparam state_t DONE_ST = S_FETCH1;
`endif
  state_t  state, state_nx;
  opcode_t opc;
  logic    unused_addr;
  assign opc         = opcode_t'(ir[IR_W-1 -: OPC_W]);
  assign unused_addr = ^ir[IR_W-OPC_W-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_FETCH1;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH1:   state_nx = S_FETCH2;
      S_FETCH2:   state_nx = mem_ready ? S_DECODE : S_FETCH2;
      S_DECODE:   state_nx = opc inside {OP_LDAC, OP_STAC, OP_ADD} ? S_MEM_ADDR :
                             opc == OP_HALT ? S_HALT : DONE_ST;
      S_MEM_ADDR: state_nx = opc == OP_STAC ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_nx = mem_ready ? S_EXEC : S_MEM_RD;
      S_EXEC:     state_nx = DONE_ST;
      S_MEM_WR:   state_nx = mem_ready ? DONE_ST : S_MEM_WR;
      S_HALT:     state_nx = S_HALT;
`ifdef CPU_CTRL_SINGLE_STEP_EN
      S_STEP_WAIT: state_nx = step ? S_FETCH1 : S_STEP_WAIT;
`endif
      default:    state_nx = S_FETCH1;
    endcase
  end
  cpu_ctrl_out_decode u_out (
    .state      (state),
    .opc        (opc),
    .z_flag     (z_flag),
    .mem_ready  (mem_ready),
    .rst        (rst),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .ar_load    (ar_load),
    .ar_src     (ar_src),
    .ir_load    (ir_load),
    .dr_load    (dr_load),
    .ac_load    (ac_load),
    .ac_inc     (ac_inc),
    .alu_op     (alu_op),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .instr_done (instr_done),
    .halted     (halted)
  );
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: table-driven cycle checks of cpu_ctrl_seq plus hand-written reset/halt corner cases.
module tb_cpu_ctrl_seq;
  localparam logic [12:0] PL  = 13'h1000;
  localparam logic [12:0] PI  = 13'h0800;
  localparam logic [12:0] AL  = 13'h0400;
  localparam logic [12:0] AS  = 13'h0200;
  localparam logic [12:0] IL  = 13'h0100;
  localparam logic [12:0] DL  = 13'h0080;
  localparam logic [12:0] ACL = 13'h0040;
  localparam logic [12:0] ACI = 13'h0020;
  localparam logic [12:0] ALU = 13'h0010;
  localparam logic [12:0] RD  = 13'h0008;
  localparam logic [12:0] WR  = 13'h0004;
  localparam logic [12:0] DN  = 13'h0002;
  localparam logic [12:0] HT  = 13'h0001;
  localparam logic [12:0] FT  = RD | IL | PI;
  typedef struct {
    logic [7:0]  ir;
    logic        mr;
    logic        z;
    logic [12:0] exp;
    string       name;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ir = 8'h00;
  logic z_flag = 1'b0;
  logic mem_ready = 1'b1;
  logic pc_load, pc_inc, ar_load, ar_src, ir_load, dr_load, ac_load, ac_inc;
  logic alu_op, mem_rd, mem_wr, instr_done, halted;
  logic [12:0] outs;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  assign outs = {pc_load, pc_inc, ar_load, ar_src, ir_load, dr_load, ac_load, ac_inc,
                 alu_op, mem_rd, mem_wr, instr_done, halted};
  cpu_ctrl_seq #(.IR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ir         (ir),
    .z_flag     (z_flag),
    .mem_ready  (mem_ready),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step       (1'b1),
`endif
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .ar_load    (ar_load),
    .ar_src     (ar_src),
    .ir_load    (ir_load),
    .dr_load    (dr_load),
    .ac_load    (ac_load),
    .ac_inc     (ac_inc),
    .alu_op     (alu_op),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .instr_done (instr_done),
    .halted     (halted)
  );
  task automatic check(input string name, input logic [12:0] exp);
    n_cmp++;
    if (outs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (pl pi al as il dl acl aci alu rd wr dn ht)", name, outs, exp);
    end
  endtask
  task automatic cyc(input logic [7:0] i, input logic mr, input logic z, input logic [12:0] exp,
                     input string name);
    ir = i;
    mem_ready = mr;
    z_flag = z;
    #1;
    check(name, exp);
    @(posedge clk);
    #2;
  endtask
  task automatic add(input logic [7:0] i, input logic mr, input logic z, input logic [12:0] exp,
                     input string name);
    vec_t v;
    v.ir = i; v.mr = mr; v.z = z; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask
  initial begin
    add(8'h00, 1, 0, AL, "nop_c1");
    add(8'h00, 1, 0, FT, "nop_c2");
    add(8'h00, 1, 0, DN, "nop_c3");
    add(8'h00, 1, 0, AL, "nop2_c1");
    add(8'h00, 1, 0, FT, "nop2_c2");
    add(8'h00, 1, 0, DN, "nop2_c3");
    add(8'h2A, 1, 0, AL, "ldac_c1");
    add(8'h2A, 1, 0, FT, "ldac_c2");
    add(8'h2A, 1, 0, '0, "ldac_c3");
    add(8'h2A, 1, 0, AL | AS, "ldac_c4");
    add(8'h2A, 1, 0, RD | DL, "ldac_c5");
    add(8'h2A, 1, 0, ACL | DN, "ldac_c6");
    add(8'h80, 1, 0, AL, "inac_c1");
    add(8'h80, 1, 0, FT, "inac_c2");
    add(8'h80, 1, 0, ACI | DN, "inac_c3");
    add(8'hA0, 1, 0, AL, "jmp_c1");
    add(8'hA0, 1, 0, FT, "jmp_c2");
    add(8'hA0, 1, 0, PL | DN, "jmp_c3");
    add(8'hC5, 1, 1, AL, "jmpz0_c1");
    add(8'hC5, 1, 1, FT, "jmpz0_c2");
    add(8'hC5, 1, 0, DN, "jmpz0_c3");
    add(8'hC5, 1, 0, AL, "jmpz1_c1");
    add(8'hC5, 1, 0, FT, "jmpz1_c2");
    add(8'hC5, 1, 1, PL | DN, "jmpz1_c3");
    add(8'hC5, 1, 1, AL, "jmpz1_after");
    add(8'h6A, 1, 0, FT, "add_c2");
    add(8'h6A, 1, 0, '0, "add_c3");
    add(8'h6A, 1, 0, AL | AS, "add_c4");
    add(8'h6A, 0, 0, RD, "add_wait1");
    add(8'h6A, 0, 0, RD, "add_wait2");
    add(8'h6A, 0, 0, RD, "add_wait3");
    add(8'h6A, 1, 0, RD | DL, "add_rd");
    add(8'h6A, 1, 0, ACL | ALU | DN, "add_exec");
    add(8'h45, 1, 0, AL, "stac_c1");
    add(8'h45, 1, 0, FT, "stac_c2");
    add(8'h45, 1, 0, '0, "stac_c3");
    add(8'h45, 1, 0, AL | AS, "stac_c4");
    add(8'h45, 1, 0, WR | DN, "stac_c5");
    add(8'h00, 0, 0, AL, "fwait_c1");
    add(8'h00, 0, 0, RD, "fwait_c2");
    add(8'h00, 1, 0, FT, "fwait_c3");
    add(8'h00, 0, 0, DN, "fwait_c4");
    add(8'hE0, 1, 0, AL, "halt_c1");
    add(8'hE0, 1, 0, FT, "halt_c2");
    add(8'hE0, 1, 0, '0, "halt_c3");
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", '0);
    rst = 1'b0;
    foreach (tbl[k]) cyc(tbl[k].ir, tbl[k].mr, tbl[k].z, tbl[k].exp, tbl[k].name);
    for (int i = 0; i < 20; i++) cyc(8'hE0, i[0], i[1], HT, "halt_hold");
    rst = 1'b1;
    #1;
    check("halt_async_rst", '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc(8'h45, 1, 0, AL, "post_rst_c1");
    cyc(8'h45, 1, 0, FT, "post_rst_c2");
    cyc(8'h45, 1, 0, '0, "stac2_c3");
    cyc(8'h45, 1, 0, AL | AS, "stac2_c4");
    cyc(8'h45, 0, 0, WR, "stac2_wait1");
    cyc(8'h45, 0, 0, WR, "stac2_wait2");
    ir = 8'h45;
    mem_ready = 1'b0;
    #1;
    check("stac_wr_pre_rst", WR);
    rst = 1'b1;
    #1;
    check("stac_async_rst", '0);
    mem_ready = 1'b1;
    #1;
    check("stac_rst_no_done", '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc(8'h00, 1, 0, AL, "post_rst2_c1");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
